// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the router-to-router credit link.
package noc_link_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } tx_state_t;

    // Counter width able to hold every value 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return int'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/noc_credit_tx_if.sv
// Upstream valid/ready flit port plus the forward send link and backward credit wire.
interface noc_credit_tx_if #(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned DEST_WIDTH = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] in_data;
    logic [DEST_WIDTH-1:0] in_dest;
    logic                  in_is_tail;
    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in;

    // Transmitter side: drives the link and in_ready.
    modport master (
        input  in_valid, in_data, in_dest, in_is_tail, credit_in,
        output in_ready, data_out, dest_out, is_tail_out, send_out
    );

    // Environment side: upstream source and downstream receiver.
    modport slave (
        output in_valid, in_data, in_dest, in_is_tail, credit_in,
        input  in_ready, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/noc_credit_counter.sv
// Downstream buffer credit counter: decrements on consume, increments on returned
// credit, saturates at DEPTH and flags a sticky error on an excess credit.
module noc_credit_counter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             consume,
    input  logic             credit_in,
    output logic [WIDTH-1:0] count,
    output logic             nonzero,
    output logic             overflow_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             nonzero_q, nonzero_d;
    logic             err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (consume && !credit_in) begin
            count_d = count_q - WIDTH'(1);
        end else if (credit_in && !consume) begin
            if (count_q == WIDTH'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
        nonzero_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= WIDTH'(DEPTH);
            nonzero_q <= (DEPTH != 0);
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            nonzero_q <= nonzero_d;
            err_q     <= err_d;
        end
    end

    assign count        = count_q;
    assign nonzero      = nonzero_q;
    assign overflow_err = err_q;

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-based transmit end of a router link: accepts flits upstream and drives the
// registered send link without overrunning the downstream input buffer.
module noc_credit_tx
    import noc_link_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH        = 64,
    parameter int unsigned DEST_WIDTH        = 6,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4,
    parameter int unsigned CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    noc_credit_tx_if.master         link,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    pkt_active,
    output logic                    credit_err
);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    tx_state_t             state_q;
    flit_t                 flit_q;
    logic [DEST_WIDTH-1:0] head_dest_q;
    logic                  send_q;
    logic                  pkt_active_q;
    logic                  ready;
    logic                  fire;

    assign fire = link.in_valid & ready;

    noc_credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .WIDTH (CREDIT_WIDTH)
    ) u_credits (
        .clk          (clk_noc),
        .rst_n        (rst_n),
        .consume      (fire),
        .credit_in    (link.credit_in),
        .count        (credits_avail),
        .nonzero      (ready),
        .overflow_err (credit_err)
    );

    // Body flits reuse the head's destination; in_dest is only meaningful on heads.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pkt_active_q <= 1'b0;
            send_q       <= 1'b0;
            flit_q       <= '0;
            head_dest_q  <= '0;
        end else begin
            send_q <= fire;
            if (fire) begin
                flit_q.data    <= link.in_data;
                flit_q.is_tail <= link.in_is_tail;
                unique case (state_q)
                    IDLE: begin
                        flit_q.dest <= link.in_dest;
                        if (!link.in_is_tail) begin
                            head_dest_q  <= link.in_dest;
                            state_q      <= BODY;
                            pkt_active_q <= 1'b1;
                        end
                    end
                    BODY: begin
                        flit_q.dest <= head_dest_q;
                        if (link.in_is_tail) begin
                            state_q      <= IDLE;
                            pkt_active_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        pkt_active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign link.in_ready    = ready;
    assign link.send_out    = send_q;
    assign link.data_out    = flit_q.data;
    assign link.dest_out    = flit_q.dest;
    assign link.is_tail_out = flit_q.is_tail;
    assign pkt_active       = pkt_active_q;

endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed and randomized checks of noc_credit_tx against a packet-level reference model.
module tb_noc_credit_tx;

    localparam int unsigned FW    = 64;
    localparam int unsigned DW    = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] credits_avail;
    logic          pkt_active;
    logic          credit_err;

    noc_credit_tx_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) link ();

    noc_credit_tx #(
        .FLIT_WIDTH        (FW),
        .DEST_WIDTH        (DW),
        .FLIT_BUFFER_DEPTH (DEPTH),
        .CREDIT_WIDTH      (CW)
    ) dut (
        .clk_noc       (clk),
        .rst_n         (rst_n),
        .link          (link.master),
        .credits_avail (credits_avail),
        .pkt_active    (pkt_active),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: credit pool, packet membership and the flit last put on the link.
    bit            model_ok = 1'b0;
    int            m_credits;
    bit            m_err;
    bit            m_in_pkt;
    logic [DW-1:0] m_head;
    bit            m_send;
    logic [FW-1:0] m_data;
    logic [DW-1:0] m_dest;
    bit            m_tail;

    always @(posedge clk) begin
        bit f;
        if (!rst_n) begin
            m_credits = DEPTH;
            m_err     = 1'b0;
            m_in_pkt  = 1'b0;
            m_head    = '0;
            m_send    = 1'b0;
            m_data    = '0;
            m_dest    = '0;
            m_tail    = 1'b0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            f      = link.in_valid && (m_credits > 0);
            m_send = f;
            if (f) begin
                m_data = link.in_data;
                m_tail = link.in_is_tail;
                m_dest = m_in_pkt ? m_head : link.in_dest;
                if (!m_in_pkt && !link.in_is_tail) begin
                    m_head   = link.in_dest;
                    m_in_pkt = 1'b1;
                end else if (link.in_is_tail) begin
                    m_in_pkt = 1'b0;
                end
            end
            m_credits = m_credits - int'(f) + int'(link.credit_in);
            if (m_credits > int'(DEPTH)) begin
                m_credits = DEPTH;
                m_err     = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready", 64'(link.in_ready), 64'(m_credits != 0));
            chk("credits_avail", 64'(credits_avail), 64'(m_credits));
            chk("pkt_active", 64'(pkt_active), 64'(m_in_pkt));
            chk("credit_err", 64'(credit_err), 64'(m_err));
            chk("send_out", 64'(link.send_out), 64'(m_send));
            chk("data_out", 64'(link.data_out), 64'(m_data));
            chk("dest_out", 64'(link.dest_out), 64'(m_dest));
            chk("is_tail_out", 64'(link.is_tail_out), 64'(m_tail));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit t, input bit c);
        link.in_valid   = v;
        link.in_data    = {$urandom, $urandom};
        link.in_dest    = d;
        link.in_is_tail = t;
        link.credit_in  = c;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready", 64'(link.in_ready), 64'd1);
        chk("rst_credits", 64'(credits_avail), 64'd4);
        chk("rst_send", 64'(link.send_out), 64'd0);
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_pkt", 64'(pkt_active), 64'd0);

        // Six single-flit packets against four credits: only four go out.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            tick();
            chk("burst_send", 64'(link.send_out), 64'(i <= 4));
            if (i == 4) chk("burst_ready_4", 64'(link.in_ready), 64'd0);
        end
        chk("burst_credits", 64'(credits_avail), 64'd0);
        chk("burst_ready", 64'(link.in_ready), 64'd0);

        // One returned credit lets exactly one more flit through.
        drive(1'b1, 6'h01, 1'b1, 1'b1);
        tick();
        chk("ret_ready", 64'(link.in_ready), 64'd1);
        chk("ret_credits", 64'(credits_avail), 64'd1);
        drive(1'b1, 6'h01, 1'b1, 1'b0);
        tick();
        chk("ret_send", 64'(link.send_out), 64'd1);
        chk("ret_credits0", 64'(credits_avail), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            tick();
        end

        // Three-flit packet: body/tail dest ignored in favour of the head's.
        drive(1'b1, 6'h2A, 1'b0, 1'b0);
        tick();
        chk("pkt_h_send", 64'(link.send_out), 64'd1);
        chk("pkt_h_dest", 64'(link.dest_out), 64'h2A);
        chk("pkt_h_tail", 64'(link.is_tail_out), 64'd0);
        chk("pkt_h_active", 64'(pkt_active), 64'd1);
        drive(1'b1, 6'h15, 1'b0, 1'b0);
        tick();
        chk("pkt_b_dest", 64'(link.dest_out), 64'h2A);
        chk("pkt_b_tail", 64'(link.is_tail_out), 64'd0);
        chk("pkt_b_active", 64'(pkt_active), 64'd1);
        drive(1'b1, 6'h15, 1'b1, 1'b0);
        tick();
        chk("pkt_t_send", 64'(link.send_out), 64'd1);
        chk("pkt_t_dest", 64'(link.dest_out), 64'h2A);
        chk("pkt_t_tail", 64'(link.is_tail_out), 64'd1);
        chk("pkt_t_active", 64'(pkt_active), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("one_credit", 64'(credits_avail), 64'd1);

        // Fire and credit return in the same cycle with a single credit left.
        drive(1'b1, 6'h07, 1'b1, 1'b1);
        tick();
        chk("same_credits", 64'(credits_avail), 64'd1);
        chk("same_ready", 64'(link.in_ready), 64'd1);
        chk("same_send", 64'(link.send_out), 64'd1);
        drive(1'b1, 6'h08, 1'b1, 1'b0);
        tick();
        chk("same_send2", 64'(link.send_out), 64'd1);
        chk("same_credits0", 64'(credits_avail), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Overflow: an extra credit at full is sticky until reset.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            tick();
        end
        chk("full_err0", 64'(credit_err), 64'd0);
        tick();
        chk("ovf_err", 64'(credit_err), 64'd1);
        chk("ovf_credits", 64'(credits_avail), 64'd4);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("ovf_sticky", 64'(credit_err), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ovf_cleared", 64'(credit_err), 64'd0);

        // Reset in the middle of a four-flit packet.
        drive(1'b1, 6'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'h05, 1'b0, 1'b0);
        tick();
        chk("mid_active", 64'(pkt_active), 64'd1);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        chk("mid_rst_active", 64'(pkt_active), 64'd0);
        chk("mid_rst_credits", 64'(credits_avail), 64'd4);
        chk("mid_rst_send", 64'(link.send_out), 64'd0);
        drive(1'b1, 6'h33, 1'b0, 1'b0);
        tick();
        chk("new_head_dest", 64'(link.dest_out), 64'h33);
        chk("new_head_active", 64'(pkt_active), 64'd1);
        drive(1'b1, 6'h00, 1'b1, 1'b0);
        tick();
        chk("new_tail_dest", 64'(link.dest_out), 64'h33);

        // Randomized traffic, credit returns and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            drive($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 4);
            tick();
        end

        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
